// File: rtl/bmp_stream_out.sv
// rtl/bmp_stream_out.sv - streams the image RAM out as a 24-bit BMP file over a valid/ready byte stream
// A 54-byte header is generated from the parameters, then the pixels are sent in address order, MSB first.
module bmp_stream_out #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] RAM_A,
    output logic              RAM_OE,
    input  logic [23:0]       RAM_Q,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              finish
);
    localparam int NBYTES = 54 + 3 * IMG_W * IMG_H;
    localparam int CW     = ($clog2(NBYTES + 1) > 18) ? $clog2(NBYTES + 1) : 18;
    localparam logic [CW-1:0]   LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [CW-1:0]   HDR_LAST  = CW'(53);
    localparam logic [ADDR_W:0] NPIX      = (ADDR_W + 1)'(IMG_W * IMG_H);
    localparam logic [31:0]     FILE_SIZE = 32'(NBYTES);
    localparam logic [31:0]     IMG_SIZE  = 32'(3 * IMG_W * IMG_H);

    typedef enum logic [1:0] {IDLE, HDR, PIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   byte_cnt;
    logic [ADDR_W:0] issue_cnt;
    logic            in_flight;
    logic [23:0]     nxt_pix;
    logic            nxt_vld;
    logic [23:0]     pix;
    logic [1:0]      idx;
    logic            accept;
    logic            issue;

    // Each multi-byte field is selected by its first offset, then shifted down to the wanted byte.
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [31:0] field;
        logic [5:0]  base;
        logic [5:0]  off;
        field = '0;
        base  = '0;
        if (i <= 6'd1) begin
            field = 32'h0000_4D42;
        end else if (i >= 6'd2 && i <= 6'd5) begin
            field = FILE_SIZE; base = 6'd2;
        end else if (i >= 6'd10 && i <= 6'd13) begin
            field = 32'd54;    base = 6'd10;
        end else if (i >= 6'd14 && i <= 6'd17) begin
            field = 32'd40;    base = 6'd14;
        end else if (i >= 6'd18 && i <= 6'd21) begin
            field = 32'(IMG_W); base = 6'd18;
        end else if (i >= 6'd22 && i <= 6'd25) begin
            field = 32'(IMG_H); base = 6'd22;
        end else if (i >= 6'd26 && i <= 6'd27) begin
            field = 32'd1;     base = 6'd26;
        end else if (i >= 6'd28 && i <= 6'd29) begin
            field = 32'd24;    base = 6'd28;
        end else if (i >= 6'd34 && i <= 6'd37) begin
            field = IMG_SIZE;  base = 6'd34;
        end
        off   = i - base;
        field = field >> {off, 3'b000};
        return field[7:0];
    endfunction

    assign accept = tx_valid & tx_ready;
    assign issue  = (state == HDR || state == PIX) && !nxt_vld && !in_flight && (issue_cnt < NPIX);

    always_comb begin
        tx_data = '0;
        if (tx_valid && state == HDR) begin
            tx_data = hdr_byte(byte_cnt[5:0]);
        end else if (tx_valid && state == PIX) begin
            case (idx)
                2'd0:    tx_data = pix[23:16];
                2'd1:    tx_data = pix[15:8];
                default: tx_data = pix[7:0];
            endcase
        end
    end

    assign tx_last = tx_valid && (state == PIX) && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            finish    <= 1'b0;
            tx_valid  <= 1'b0;
            RAM_A     <= '0;
            RAM_OE    <= 1'b0;
            byte_cnt  <= '0;
            issue_cnt <= '0;
            in_flight <= 1'b0;
            nxt_pix   <= '0;
            nxt_vld   <= 1'b0;
            pix       <= '0;
            idx       <= '0;
        end else begin
            finish <= 1'b0;
            // Prefetch: one read at a time, captured the cycle after the address is presented.
            if (in_flight) begin
                nxt_pix   <= RAM_Q;
                nxt_vld   <= 1'b1;
                in_flight <= 1'b0;
                if (issue_cnt == NPIX) RAM_OE <= 1'b0;
            end else if (issue) begin
                RAM_A     <= issue_cnt[ADDR_W-1:0];
                RAM_OE    <= 1'b1;
                in_flight <= 1'b1;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (accept) byte_cnt <= byte_cnt + 1'b1;

            case (state)
                IDLE: if (start) begin
                    state     <= HDR;
                    busy      <= 1'b1;
                    tx_valid  <= 1'b1;
                    byte_cnt  <= '0;
                    idx       <= '0;
                    nxt_vld   <= 1'b0;
                    RAM_A     <= '0;
                    RAM_OE    <= 1'b1;
                    in_flight <= 1'b1;
                    issue_cnt <= (ADDR_W + 1)'(1);
                end
                HDR: if (accept && byte_cnt == HDR_LAST) begin
                    state <= PIX;
                    idx   <= '0;
                    if (nxt_vld) begin
                        pix     <= nxt_pix;
                        nxt_vld <= 1'b0;
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end
                PIX: if (accept && idx == 2'd2) begin
                    idx <= '0;
                    if (byte_cnt == LAST_BYTE) begin
                        state    <= DONE;
                        tx_valid <= 1'b0;
                        finish   <= 1'b1;
                    end else if (nxt_vld) begin
                        pix     <= nxt_pix;
                        nxt_vld <= 1'b0;
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end else if (accept) begin
                    idx <= idx + 2'd1;
                end else if (!tx_valid && nxt_vld) begin
                    pix      <= nxt_pix;
                    nxt_vld  <= 1'b0;
                    tx_valid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_stream_out.sv
// tb/tb_bmp_stream_out.sv - scoreboard bench for bmp_stream_out on a small non-square image
module tb_bmp_stream_out;
    localparam int W      = 8;
    localparam int H      = 4;
    localparam int AW     = 6;
    localparam int NPIX   = W * H;
    localparam int NBYTES = 54 + 3 * NPIX;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          tx_ready;
    logic [AW-1:0] RAM_A;
    logic          RAM_OE;
    logic [23:0]   RAM_Q;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          busy;
    logic          finish;

    logic [23:0] ram [0:(1<<AW)-1];
    assign RAM_Q = RAM_OE ? ram[RAM_A] : 24'h0;

    always #5 clk = ~clk;

    bmp_stream_out #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .RAM_A(RAM_A), .RAM_OE(RAM_OE), .RAM_Q(RAM_Q),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .finish(finish)
    );

    int         passed  = 0;
    int         total   = 0;
    int         acc_cnt = 0;
    bit         bp_en   = 1'b0;
    logic [7:0] exp_q[$];
    logic       hold_vld = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push_le(input int unsigned v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endfunction

    // Reference BMP file: header fields listed in file order, then every pixel MSB first.
    function automatic void build_expected();
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(NBYTES, 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(W, 4);
        push_le(H, 4);
        push_le(1, 2);
        push_le(24, 2);
        push_le(0, 4);
        push_le(3 * NPIX, 4);
        push_le(0, 16);
        for (int a = 0; a < NPIX; a++) begin
            exp_q.push_back(ram[a][23:16]);
            exp_q.push_back(ram[a][15:8]);
            exp_q.push_back(ram[a][7:0]);
        end
    endfunction

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (hold_vld) begin
                chk("valid_held", tx_valid, 1);
                chk("data_stable", tx_data, hold_data);
                chk("last_stable", tx_last, hold_last);
            end
            if (tx_valid && tx_ready) begin
                hold_vld = 1'b0;
                chk("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("byte_data", tx_data, exp_q.pop_front());
                    chk("byte_last", tx_last, exp_q.size() == 0);
                end
                acc_cnt++;
            end else if (tx_valid) begin
                hold_vld  = 1'b1;
                hold_data = tx_data;
                hold_last = tx_last;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, tx_valid, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_last"}, tx_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_ram_oe"}, RAM_OE, 0);
        chk({tag, "_ram_a"}, RAM_A, 0);
    endtask

    task automatic run(input bit bp, input int inj_at, input int rst_at, input bit start_in_done);
        int n;
        bit done;
        bit injected;
        build_expected();
        acc_cnt  = 0;
        bp_en    = bp;
        done     = 1'b0;
        injected = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("first_busy", busy, 1);
        chk("first_valid", tx_valid, 1);
        chk("first_data", tx_data, 8'h42);
        chk("first_ram_a", RAM_A, 0);
        chk("first_ram_oe", RAM_OE, 1);
        for (n = 1; n <= 4 * NBYTES + 100; n++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                done = 1'b1;
                break;
            end
            if (rst_at >= 0 && acc_cnt >= rst_at) begin
                rst = 1'b0;
                #1 check_all_zero("midrst");
                exp_q.delete();
                hold_vld = 1'b0;
                bp_en    = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            if (inj_at >= 0 && !injected && acc_cnt >= inj_at) begin
                injected = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                n++;
                if (finish) begin
                    done = 1'b1;
                    break;
                end
            end
        end
        chk("finished_in_budget", done, 1);
        if (!bp) chk("cycle_count", n, NBYTES);
        chk("done_busy", busy, 1);
        chk("done_valid", tx_valid, 0);
        chk("done_last", tx_last, 0);
        chk("done_ram_oe", RAM_OE, 0);
        chk("all_bytes_sent", exp_q.size(), 0);
        if (start_in_done) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("finish_one_cycle", finish, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", tx_valid, 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'h0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("released");

        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'($urandom);
        ram[0] = 24'h123456;
        ram[1] = 24'hABCDEF;
        ram[NPIX-1] = 24'h0F1E2D;
        run(1'b0, 100, -1, 1'b1);

        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'(i * 24'h010101);
        run(1'b1, -1, -1, 1'b0);

        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'($urandom);
        run(1'b0, -1, 70, 1'b0);

        for (int i = 0; i < (1 << AW); i++) ram[i] = 24'($urandom);
        run(1'b1, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
